i2c_bit_phy: RTL
================

# i2c_bit_phy

Bit-level I2C physical engine sitting directly below the byte-level `i2c_ctrl` controller. It accepts one bus primitive per handshake: START/repeated START, STOP, write-bit or read-bit. It executes the primitive as four timed quarter-period phases on open-drain SCL/SDA, honouring slave clock stretching and detecting arbitration loss. It returns a one-cycle completion response carrying the sampled bit.

## Interface
- `DIV`, default 125: system clocks per quarter SCL period (125 gives 100 kHz at 50 MHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine idle, can accept a command.
- `cmd`  in  2  primitive: START=0, STOP=1, WRITE=2, READ=3.
- `cmd_bit`  in  1  data bit for WRITE; ignored otherwise.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_bit`  out  1  SDA sampled in phase C (READ/WRITE); 0 for START/STOP.
- `rsp_arb_lost`  out  1  valid with `rsp_valid`; 1 = arbitration lost.
- `scl_i`, `sda_i`  in  1 each  raw pad inputs (asynchronous).
- `scl_oe`, `sda_oe`  out  1 each  1 = drive line low, 0 = release.

## Operation
- `scl_i`/`sda_i` pass through 2-flop synchronizers reset to 1, giving `scl_s`/`sda_s`.
- Handshake: accept when `cmd_valid && cmd_ready`. `cmd_ready` is 1 only in IDLE. `cmd`/`cmd_bit` are captured on acceptance.
- States: IDLE, then phases A, B, C, D of the captured command, then IDLE.
- Each phase lasts DIV cycles, counted by a single down-counter reloaded at phase entry.
- Output values per phase (`scl_oe`/`sda_oe`):
  - START: A 0/0, B 0/0, C 0/1, D 1/1.
  - STOP: A 1/1, B 0/1, C 0/1, D 0/0.
  - WRITE: all phases `sda_oe`=!cmd_bit; `scl_oe` A 1, B 0, C 0, D 1.
  - READ: all phases `sda_oe`=0; `scl_oe` A 1, B 0, C 0, D 1.
- Clock stretching applies in phase B of every command, since SCL is released there. While `scl_s`==0 the counter holds at reload and does not decrement. Phase B therefore lasts DIV cycles after SCL is first seen high. No timeout.
- Sampling: on the last cycle of phase C, `sda_s` is latched into `rsp_bit` (READ/WRITE only).
- Arbitration:
  - Condition: WRITE with cmd_bit=1 and sampled `sda_s`=0.
  - Effect: skip phase D, release both lines, go IDLE, pulse `rsp_valid` with `rsp_arb_lost`=1.
- In IDLE, `scl_oe`/`sda_oe` hold the values they had at the end of phase D. SCL stays low after START/bit; both lines are released after STOP.
- Illegal sequencing (e.g. WRITE with no preceding START) is not checked. The engine executes it as given.

## Timing
- Reset values: `scl_oe`=0, `sda_oe`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_bit`=0, `rsp_arb_lost`=0, state IDLE.
- Outputs are registered and change on the first cycle of each phase.
- Acceptance edge = cycle 0. With no stretching:
  - A occupies cycles 1..DIV.
  - B occupies DIV+1..2·DIV.
  - C occupies 2·DIV+1..3·DIV.
  - D occupies 3·DIV+1..4·DIV.
- `rsp_valid` and `cmd_ready` both assert at cycle 4·DIV+1.
- Back-to-back: a command presented with `cmd_valid` held is accepted on that same cycle 4·DIV+1, so the next phase A begins at 4·DIV+2.
- Arbitration-lost response asserts on the cycle after phase C ends (3·DIV+1). Lines are released in that same cycle.
- Stretch adds the SCL-low time seen at `scl_s`, plus 2 cycles of synchronizer latency.
- Asynchronous reset mid-command releases both lines immediately and discards the command. No response is issued.

## Structure
- Package `i2c_pkg`: command encoding constants CMD_START/CMD_STOP/CMD_WRITE/CMD_READ and the phase enumeration. The package is shared with `i2c_ctrl`.
- Sub-module `i2c_sync`: 2-flop synchronizer with asynchronous reset to 1, instantiated for SCL and for SDA.
- The main FSM, phase counter and response registers live in `i2c_bit_phy`.

## Test plan
All scenarios use DIV=4 and a pull-up bus model (line = !oe_master && !oe_slave).
- START from idle, accepted at cycle 0 -> `sda_oe`=1 from cycle 9, `scl_oe`=1 from cycle 13, `rsp_valid` pulse at cycle 17, `rsp_bit`=0, `cmd_ready` high at 17.
- WRITE 0 then READ with slave driving SDA low, back-to-back -> second command accepted at cycle 17. Read response has `rsp_bit`=0 at cycle 34. SCL toggles 1,0,0,1 per phase.
- Slave holds SCL low for 10 extra cycles during phase B of a READ -> response delayed by 10+2 cycles. `rsp_bit` matches the slave bit.
- WRITE 1 while another master pulls SDA low -> `rsp_valid`=1 and `rsp_arb_lost`=1 at cycle 13. Both `oe` outputs are 0 from cycle 13.
- STOP after a bit -> `scl_oe`=0 from cycle 5 while `sda_oe`=1. `sda_oe`=0 from cycle 13. Both remain 0 in IDLE.
- Assert `reset_n` low at cycle 6 of a WRITE 0 -> both `oe` outputs 0 asynchronously, `cmd_ready`=1 after release, and no `rsp_valid` ever issued for that command.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C bit engine and the byte-level controller
// above it:
//   - CMD_START / CMD_STOP / CMD_WRITE / CMD_READ : 2-bit primitive codes
//   - phase_t  : IDLE plus the four quarter-period phases A..D
//   - phase_oe : open-drain enables {scl_oe, sda_oe} for a primitive/phase
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_A    = 3'd1,
    PH_B    = 3'd2,
    PH_C    = 3'd3,
    PH_D    = 3'd4
  } phase_t;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low, 0 releases it.
  function automatic logic [1:0] phase_oe(input logic [1:0] op,
                                          input logic       data,
                                          input phase_t     ph);
    logic scl_low;
    // Data bits hold SCL low in the outer quarters, high in the middle two.
    scl_low  = (ph == PH_A) || (ph == PH_D);
    phase_oe = 2'b00;
    case (op)
      CMD_START: begin
        // SDA falls while SCL is high, then SCL is pulled low.
        case (ph)
          PH_C:    phase_oe = 2'b01;
          PH_D:    phase_oe = 2'b11;
          default: phase_oe = 2'b00;
        endcase
      end
      CMD_STOP: begin
        // SDA held low through the SCL rise, then released while SCL is high.
        case (ph)
          PH_A:    phase_oe = 2'b11;
          PH_B:    phase_oe = 2'b01;
          PH_C:    phase_oe = 2'b01;
          default: phase_oe = 2'b00;
        endcase
      end
      CMD_WRITE: phase_oe = {scl_low, ~data};
      default:   phase_oe = {scl_low, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync
// Two-flop synchronizer for an asynchronous pad input. Resets to 1 so an
// idle (pulled-up) bus line reads high straight out of reset.
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   d       in  raw asynchronous input
//   q       out synchronized output (2-cycle latency)
module i2c_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/i2c_bit_phy.sv
// i2c_bit_phy
// Bit-level I2C engine: executes one primitive (START, STOP, WRITE bit,
// READ bit) per handshake as four DIV-cycle quarter phases on open-drain
// SCL/SDA, honours clock stretching in phase B and reports arbitration loss.
//   DIV          quarter SCL period in system clocks (>= 2)
//   clk, reset_n system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd, cmd_bit   command handshake
//   rsp_valid, rsp_bit, rsp_arb_lost    one-cycle completion response
//   scl_i, sda_i                        raw pad inputs
//   scl_oe, sda_oe                      1 = drive line low
module i2c_bit_phy
  import i2c_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       rsp_arb_lost,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int             CW     = $clog2(DIV);
  localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0]  ONE    = CW'(1);
  // Cycles at the start of phase B during which scl_s still shows the SCL
  // level from before our own release (synchronizer latency).
  localparam logic [1:0]     BLANK  = 2'd2;

  // Pad synchronizers: bit 0 = SCL, bit 1 = SDA.
  logic [1:0] pad_raw;
  logic [1:0] pad_s;
  logic       scl_s;
  logic       sda_s;

  assign pad_raw = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      i2c_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_raw[gi]),
        .q       (pad_s[gi])
      );
    end
  endgenerate

  assign scl_s = pad_s[0];
  assign sda_s = pad_s[1];

  phase_t         phase_reg,     phase_next;
  logic [CW-1:0]  cnt_reg,       cnt_next;
  logic [1:0]     blank_reg,     blank_next;
  logic [1:0]     cmd_reg,       cmd_next;
  logic           bit_reg,       bit_next;
  logic           scl_oe_reg,    scl_oe_next;
  logic           sda_oe_reg,    sda_oe_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic           rsp_bit_reg,   rsp_bit_next;
  logic           rsp_arb_reg,   rsp_arb_next;
  logic           cnt_last;
  logic [CW-1:0]  cnt_dec;

  assign cnt_last = (cnt_reg == '0);
  assign cnt_dec  = cnt_reg - ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg     <= PH_IDLE;
      cnt_reg       <= RELOAD;
      blank_reg     <= 2'd0;
      cmd_reg       <= CMD_START;
      bit_reg       <= 1'b0;
      scl_oe_reg    <= 1'b0;
      sda_oe_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_bit_reg   <= 1'b0;
      rsp_arb_reg   <= 1'b0;
    end else begin
      phase_reg     <= phase_next;
      cnt_reg       <= cnt_next;
      blank_reg     <= blank_next;
      cmd_reg       <= cmd_next;
      bit_reg       <= bit_next;
      scl_oe_reg    <= scl_oe_next;
      sda_oe_reg    <= sda_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_bit_reg   <= rsp_bit_next;
      rsp_arb_reg   <= rsp_arb_next;
    end
  end

  always_comb begin
    phase_next     = phase_reg;
    cnt_next       = cnt_reg;
    blank_next     = blank_reg;
    cmd_next       = cmd_reg;
    bit_next       = bit_reg;
    scl_oe_next    = scl_oe_reg;
    sda_oe_next    = sda_oe_reg;
    rsp_valid_next = 1'b0;
    rsp_bit_next   = rsp_bit_reg;
    rsp_arb_next   = rsp_arb_reg;

    case (phase_reg)
      PH_IDLE: begin
        // Lines keep their end-of-phase-D levels while idle.
        if (cmd_valid) begin
          cmd_next                   = cmd;
          bit_next                   = cmd_bit;
          phase_next                 = PH_A;
          cnt_next                   = RELOAD;
          {scl_oe_next, sda_oe_next} = phase_oe(cmd, cmd_bit, PH_A);
        end
      end

      PH_A: begin
        if (cnt_last) begin
          phase_next                 = PH_B;
          cnt_next                   = RELOAD;
          blank_next                 = BLANK;
          {scl_oe_next, sda_oe_next} = phase_oe(cmd_reg, bit_reg, PH_B);
        end else begin
          cnt_next = cnt_dec;
        end
      end

      PH_B: begin
        if (blank_reg != 2'd0) begin
          // scl_s cannot yet reflect our release; count normally. With
          // DIV == 2 the counter reaches 0 here and waits for the first
          // real SCL observation before leaving the phase.
          blank_next = blank_reg - 2'd1;
          if (!cnt_last) begin
            cnt_next = cnt_dec;
          end
        end else if (!scl_s) begin
          // A slave is stretching SCL: restart the high quarter.
          cnt_next = RELOAD;
        end else if (cnt_last) begin
          phase_next                 = PH_C;
          cnt_next                   = RELOAD;
          {scl_oe_next, sda_oe_next} = phase_oe(cmd_reg, bit_reg, PH_C);
        end else begin
          cnt_next = cnt_dec;
        end
      end

      PH_C: begin
        if (cnt_last) begin
          rsp_bit_next = ((cmd_reg == CMD_WRITE) || (cmd_reg == CMD_READ)) ? sda_s : 1'b0;
          if ((cmd_reg == CMD_WRITE) && bit_reg && !sda_s) begin
            // Someone else holds SDA low while we send a 1: back off now.
            phase_next     = PH_IDLE;
            scl_oe_next    = 1'b0;
            sda_oe_next    = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_arb_next   = 1'b1;
          end else begin
            phase_next                 = PH_D;
            cnt_next                   = RELOAD;
            {scl_oe_next, sda_oe_next} = phase_oe(cmd_reg, bit_reg, PH_D);
          end
        end else begin
          cnt_next = cnt_dec;
        end
      end

      PH_D: begin
        if (cnt_last) begin
          phase_next     = PH_IDLE;
          rsp_valid_next = 1'b1;
          rsp_arb_next   = 1'b0;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      default: begin
        phase_next = PH_IDLE;
      end
    endcase
  end

  assign cmd_ready    = (phase_reg == PH_IDLE);
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_bit      = rsp_bit_reg;
  assign rsp_arb_lost = rsp_arb_reg;
  assign scl_oe       = scl_oe_reg;
  assign sda_oe       = sda_oe_reg;

endmodule
